// File: rtl/usb_pkg.sv
// Shared constants, types and helpers for the full-speed USB transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package usb_pkg;

  // Bus line state as driven onto the pair.
  typedef struct packed {
    logic dp;
    logic dm;
  } line_t;

  localparam line_t LINE_J   = '{dp: 1'b1, dm: 1'b0};
  localparam line_t LINE_K   = '{dp: 1'b0, dm: 1'b1};
  localparam line_t LINE_SE0 = '{dp: 1'b0, dm: 1'b0};

  // PID nibbles (low nibble of the PID byte).
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;

  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_e;

  // One payload bit through the CRC16 register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

  // Bit reversal so a shift-right serialiser sends the MSB first.
  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

endpackage

// File: rtl/usb_tx_bitgen.sv
// Bit-time generator: bit timer, bit stuffing and NRZI line driver.
// Latency: an accepted bit is on the lines the cycle after the handshake and held CLKS_PER_BIT cycles.
// Backpressure: bit_rdy_o only at a bit boundary with no stuff bit owed; se0_i/j_i obey the same slot.
//
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   bit_vld_i/_dat_i    raw (pre-stuff, pre-NRZI) bit offered for the next bit time
//   bit_rdy_o           a bit time starts this edge and no stuff bit is due
//   se0_i, j_i          request SE0 / forced J for the next bit time (EOP)
//   d_plus_o, d_minus_o registered line outputs
module usb_tx_bitgen
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic bit_vld_i,
  input  logic bit_dat_i,
  input  logic se0_i,
  input  logic j_i,
  output logic bit_rdy_o,
  output logic d_plus_o,
  output logic d_minus_o
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    ones_q, ones_d;
  logic          level_q, level_d;   // NRZI level, 1 = J
  line_t         line_q, line_d;
  logic          wrap;
  logic          stuff_pend;

  // The timer parks at TMAX while idle so the first bit of a packet
  // can go out on the very edge that accepts it.
  assign wrap       = (timer_q == TMAX);
  assign stuff_pend = (ones_q == 3'd6);
  assign bit_rdy_o  = wrap & ~stuff_pend;

  always_comb begin
    timer_d = timer_q;
    ones_d  = ones_q;
    level_d = level_q;
    line_d  = line_q;
    if (!wrap) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = '0;
      if (stuff_pend) begin
        // Stuffed 0: toggle without consuming an upstream bit.
        level_d = ~level_q;
        ones_d  = 3'd0;
        line_d  = '{dp: ~level_q, dm: level_q};
      end else if (bit_vld_i) begin
        level_d = bit_dat_i ? level_q : ~level_q;
        ones_d  = bit_dat_i ? ones_q + 3'd1 : 3'd0;
        line_d  = '{dp: level_d, dm: ~level_d};
      end else if (se0_i) begin
        level_d = 1'b1;
        ones_d  = 3'd0;
        line_d  = LINE_SE0;
      end else if (j_i) begin
        level_d = 1'b1;
        ones_d  = 3'd0;
        line_d  = LINE_J;
      end else begin
        // Nothing to send: rest at J with the timer parked.
        timer_d = TMAX;
        level_d = 1'b1;
        ones_d  = 3'd0;
        line_d  = LINE_J;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= TMAX;
      ones_q  <= 3'd0;
      level_q <= 1'b1;
      line_q  <= LINE_J;
    end else begin
      timer_q <= timer_d;
      ones_q  <= ones_d;
      level_q <= level_d;
      line_q  <= line_d;
    end
  end

  assign d_plus_o  = line_q.dp;
  assign d_minus_o = line_q.dm;

endmodule

// File: rtl/usb_tx.sv
// Full-speed USB packet transmitter: SYNC, PID, payload, CRC16, EOP.
// Latency: first SYNC bit on the lines the cycle after the accepted tx_start.
// Backpressure: tx_start ignored while busy; an empty FIFO at a byte boundary ends the payload.
//
// Ports:
//   sysclk, n_rst       clock, async active-low reset
//   tx_start, tx_pid    packet request and PID nibble (latched on accept)
//   tx_data, tx_empty   FIFO head byte and empty flag
//   get_tx_data         one-cycle pop strobe, issued the cycle after the head is captured
//   d_plus, d_minus     bus pair
//   tx_busy, tx_done    packet in progress / one-cycle end-of-packet pulse
module usb_tx
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_BYTES    = 64
) (
  input  logic       sysclk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       get_tx_data,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(MAX_BYTES + 1);

  tx_state_e     state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [15:0]   crc_q, crc_d;
  logic [3:0]    pid_q, pid_d;
  logic          load_pend_q, load_pend_d;
  logic          eop_cnt_q, eop_cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          get_q, get_d;

  logic          bit_vld, bit_dat, bit_rdy, se0_req, j_req;
  logic [15:0]   crc_tx;

  assign crc_tx = ~crc_q;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bit_idx_d   = bit_idx_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    pid_d       = pid_q;
    load_pend_d = load_pend_q;
    eop_cnt_d   = eop_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    get_d       = 1'b0;
    bit_vld     = 1'b0;
    bit_dat     = sh_q[0];
    se0_req     = 1'b0;
    j_req       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The bit generator is always at a boundary while idle, so the
        // first SYNC bit is handed over on the accepting edge itself.
        if (tx_start && bit_rdy) begin
          bit_vld     = 1'b1;
          bit_dat     = SYNC_BYTE[0];
          sh_d        = {1'b0, SYNC_BYTE[7:1]};
          bit_idx_d   = 3'd1;
          pid_d       = tx_pid;
          byte_cnt_d  = '0;
          load_pend_d = 1'b0;
          eop_cnt_d   = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_SYNC;
        end
      end

      ST_SYNC, ST_PID, ST_CRC_LO, ST_CRC_HI: begin
        bit_vld = 1'b1;
        if (bit_rdy) begin
          sh_d      = {1'b0, sh_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            case (state_q)
              ST_SYNC: begin
                sh_d    = {~pid_q, pid_q};
                state_d = ST_PID;
              end
              ST_PID: begin
                if (pid_q[1:0] == 2'b11) begin
                  crc_d       = CRC16_INIT;
                  load_pend_d = 1'b1;
                  state_d     = ST_DATA;
                end else begin
                  state_d = ST_EOP_SE0;
                end
              end
              ST_CRC_LO: begin
                sh_d    = rev8(crc_tx[7:0]);
                state_d = ST_CRC_HI;
              end
              default: state_d = ST_EOP_SE0;
            endcase
          end
        end
      end

      ST_DATA: begin
        if (load_pend_q) begin
          // Byte boundary: a whole bit time remains before the next bit
          // is due, so the fetch decision takes its own cycle.
          load_pend_d = 1'b0;
          if (!tx_empty && (byte_cnt_q < CW'(MAX_BYTES))) begin
            sh_d       = tx_data;
            get_d      = 1'b1;
            byte_cnt_d = byte_cnt_q + 1'b1;
          end else begin
            sh_d    = rev8(crc_tx[15:8]);
            state_d = ST_CRC_LO;
          end
        end else begin
          bit_vld = 1'b1;
          if (bit_rdy) begin
            sh_d      = {1'b0, sh_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            crc_d     = crc16_step(crc_q, sh_q[0]);
            if (bit_idx_q == 3'd7) load_pend_d = 1'b1;
          end
        end
      end

      ST_EOP_SE0: begin
        // A stuff bit owed by the last CRC bit withholds bit_rdy, so it
        // goes out before the first SE0.
        se0_req = 1'b1;
        if (bit_rdy) begin
          eop_cnt_d = ~eop_cnt_q;
          if (eop_cnt_q) begin
            eop_cnt_d = 1'b0;
            state_d   = ST_EOP_J;
          end
        end
      end

      ST_EOP_J: begin
        // First boundary starts the J bit, the next one ends it.
        j_req = ~eop_cnt_q;
        if (bit_rdy) begin
          if (!eop_cnt_q) begin
            eop_cnt_d = 1'b1;
          end else begin
            eop_cnt_d = 1'b0;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      sh_q        <= 8'h00;
      bit_idx_q   <= 3'd0;
      byte_cnt_q  <= '0;
      crc_q       <= CRC16_INIT;
      pid_q       <= 4'h0;
      load_pend_q <= 1'b0;
      eop_cnt_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      get_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      bit_idx_q   <= bit_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      pid_q       <= pid_d;
      load_pend_q <= load_pend_d;
      eop_cnt_q   <= eop_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      get_q       <= get_d;
    end
  end

  usb_tx_bitgen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bitgen (
    .clk_i     (sysclk),
    .rst_ni    (n_rst),
    .bit_vld_i (bit_vld),
    .bit_dat_i (bit_dat),
    .se0_i     (se0_req),
    .j_i       (j_req),
    .bit_rdy_o (bit_rdy),
    .d_plus_o  (d_plus),
    .d_minus_o (d_minus)
  );

  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign get_tx_data = get_q;

endmodule

// File: tb/tb_usb_tx.sv
// Scoreboard bench for usb_tx: a reference model queues the expected line symbols,
// a monitor checks every cycle of every symbol plus the done/busy handshake.
// FIFO is modelled as a byte queue popped on get_tx_data.
module tb_usb_tx;
  import usb_pkg::*;

  localparam int CPB  = 8;
  localparam int MAXB = 64;

  logic       sysclk;
  logic       n_rst;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic [7:0] tx_data;
  logic       tx_empty;
  logic       get_tx_data;
  logic       d_plus;
  logic       d_minus;
  logic       tx_busy;
  logic       tx_done;

  usb_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
    .sysclk      (sysclk),
    .n_rst       (n_rst),
    .tx_start    (tx_start),
    .tx_pid      (tx_pid),
    .tx_data     (tx_data),
    .tx_empty    (tx_empty),
    .get_tx_data (get_tx_data),
    .d_plus      (d_plus),
    .d_minus     (d_minus),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int pop_cnt = 0;
  bit mon_en = 1'b1;

  logic [7:0] fifo_q[$];
  logic [7:0] pl_q[$];
  logic [1:0] exp_sym_q[$];
  int         exp_len_q[$];

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
  endtask

  // Reference model: bit list from the packet rules, then stuffing and NRZI.
  task automatic model_push(input logic [3:0] pid, input int nb);
    bit          bq[$];
    logic [7:0]  sb;
    logic [15:0] crc, c;
    bit          b, lvl;
    int          ones, cnt;
    sb = SYNC_BYTE;
    for (int i = 0; i < 8; i++) bq.push_back(sb[i]);
    sb = {~pid, pid};
    for (int i = 0; i < 8; i++) bq.push_back(sb[i]);
    if (pid[1:0] == 2'b11) begin
      crc = 16'hFFFF;
      for (int k = 0; k < nb; k++) begin
        sb = pl_q[k];
        for (int i = 0; i < 8; i++) begin
          b = sb[i];
          bq.push_back(b);
          crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? 16'h8005 : 16'h0000);
        end
      end
      c = ~crc;
      for (int i = 15; i >= 0; i--) bq.push_back(c[i]);
    end
    ones = 0; lvl = 1'b1; cnt = 0;
    foreach (bq[i]) begin
      if (!bq[i]) lvl = ~lvl;
      exp_sym_q.push_back({lvl, ~lvl}); cnt++;
      if (bq[i]) ones++; else ones = 0;
      if (ones == 6) begin
        lvl = ~lvl;
        exp_sym_q.push_back({lvl, ~lvl}); cnt++;
        ones = 0;
      end
    end
    exp_sym_q.push_back(2'b00);
    exp_sym_q.push_back(2'b00);
    exp_sym_q.push_back(2'b10);
    exp_len_q.push_back(cnt + 3);
  endtask

  // FIFO model: head visible on tx_data, popped when the strobe is seen.
  initial begin
    tx_data  = 8'h00;
    tx_empty = 1'b1;
    forever begin
      @(negedge sysclk);
      if (get_tx_data === 1'b1) begin
        pop_cnt++;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      tx_empty = (fifo_q.size() == 0);
      tx_data  = tx_empty ? 8'h00 : fifo_q[0];
    end
  end

  // Monitor: one check per symbol (all CPB cycles), then the done cycle.
  initial begin : monitor
    bit         prev_busy;
    bit         ok;
    int         n;
    logic [1:0] sym, got;
    prev_busy = 1'b0;
    forever begin
      @(negedge sysclk);
      if (tx_busy === 1'b1 && !prev_busy && mon_en) begin
        if (exp_len_q.size() == 0) begin
          chk(1'b0, "unexpected_packet", 1, 0);
        end else begin
          n = exp_len_q.pop_front();
          for (int s = 0; s < n; s++) begin
            sym = exp_sym_q.pop_front();
            ok  = 1'b1;
            got = sym;
            for (int c = 0; c < CPB; c++) begin
              if (s != 0 || c != 0) @(negedge sysclk);
              if ({d_plus, d_minus} !== sym || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
                if (ok) got = {d_plus, d_minus};
                ok = 1'b0;
              end
            end
            chk(ok, $sformatf("symbol_%0d_line_busy_done", s), int'(got), int'(sym));
          end
          @(negedge sysclk);
          chk(tx_done === 1'b1 && tx_busy === 1'b0, "done_pulse_busy_low",
              int'({tx_done, tx_busy}), 2);
        end
      end
      prev_busy = (tx_busy === 1'b1);
    end
  end

  task automatic pulse_start(input logic [3:0] pid);
    tx_start = 1'b1;
    tx_pid   = pid;
    @(negedge sysclk);
    tx_start = 1'b0;
    tx_pid   = 4'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (tx_done !== 1'b1 && k < budget) begin
      @(negedge sysclk);
      k++;
    end
    chk(tx_done === 1'b1, "wait_done_within_budget", k, budget);
  endtask

  task automatic load_fifo(input int nb, input bit all_ff);
    logic [7:0] v;
    pl_q.delete();
    for (int i = 0; i < nb; i++) begin
      v = all_ff ? 8'hFF : 8'($urandom);
      fifo_q.push_back(v);
      pl_q.push_back(v);
    end
  endtask

  task automatic send(input logic [3:0] pid, input int nb, input bit all_ff, input bit mid_start);
    int pops;
    load_fifo(nb, all_ff);
    pops = (pid[1:0] == 2'b11) ? ((nb < MAXB) ? nb : MAXB) : 0;
    model_push(pid, pops);
    pop_cnt = 0;
    pulse_start(pid);
    if (mid_start) begin
      repeat (200) @(negedge sysclk);
      pulse_start(PID_ACK);
    end
    wait_done(30000);
    chk(pop_cnt == pops, $sformatf("pop_count_pid%0h", pid), pop_cnt, pops);
    chk(fifo_q.size() == nb - pops, "fifo_remaining", fifo_q.size(), nb - pops);
    fifo_q.delete();
    @(negedge sysclk);
  endtask

  initial begin : stim
    string      ack_wave;
    logic [3:0] pids[6];
    int         k;
    pids = '{PID_OUT, PID_IN, PID_DATA0, PID_DATA1, PID_ACK, PID_NAK};
    n_rst    = 1'b0;
    tx_start = 1'b0;
    tx_pid   = 4'h0;
    repeat (3) @(negedge sysclk);
    chk(d_plus === 1'b1 && d_minus === 1'b0, "reset_line_j", int'({d_plus, d_minus}), 2);
    chk(tx_busy === 1'b0, "reset_busy", int'(tx_busy), 0);
    chk(tx_done === 1'b0, "reset_done", int'(tx_done), 0);
    chk(get_tx_data === 1'b0, "reset_get", int'(get_tx_data), 0);
    n_rst = 1'b1;
    repeat (2) @(negedge sysclk);

    // 1: ACK against the hand-written waveform.
    ack_wave = "KJKJKJKKJJKJJKKK00J";
    for (int i = 0; i < ack_wave.len(); i++)
      exp_sym_q.push_back(ack_wave[i] == "K" ? 2'b01 : (ack_wave[i] == "J" ? 2'b10 : 2'b00));
    exp_len_q.push_back(ack_wave.len());
    pop_cnt = 0;
    pulse_start(PID_ACK);
    wait_done(30000);
    chk(pop_cnt == 0, "ack_no_pops", pop_cnt, 0);
    @(negedge sysclk);

    // 2: zero-length DATA0; 3: single 0xFF byte; 4: 70-byte DATA1.
    send(PID_DATA0, 0, 1'b0, 1'b0);
    send(PID_DATA0, 1, 1'b1, 1'b0);
    send(PID_DATA1, 70, 1'b0, 1'b0);

    // Random packets.
    for (int r = 0; r < 6; r++)
      send(pids[$urandom_range(0, 5)], $urandom_range(0, 12), 1'b0, 1'b0);

    // 5a: tx_start mid-packet must not disturb the packet in flight.
    send(PID_DATA0, 4, 1'b0, 1'b1);

    // 5b: async reset during DATA.
    mon_en = 1'b0;
    load_fifo(8, 1'b0);
    pop_cnt = 0;
    pulse_start(PID_DATA1);
    k = 0;
    while (pop_cnt < 2 && k < 5000) begin
      @(negedge sysclk);
      k++;
    end
    chk(pop_cnt >= 2, "abort_reached_data", pop_cnt, 2);
    #2 n_rst = 1'b0;
    #1;
    chk(d_plus === 1'b1 && d_minus === 1'b0, "abort_line_j", int'({d_plus, d_minus}), 2);
    chk(tx_busy === 1'b0, "abort_busy", int'(tx_busy), 0);
    chk(tx_done === 1'b0, "abort_done", int'(tx_done), 0);
    @(negedge sysclk);
    repeat (2) @(negedge sysclk);
    n_rst = 1'b1;
    fifo_q.delete();
    @(negedge sysclk);
    mon_en = 1'b1;
    @(negedge sysclk);
    send(PID_ACK, 0, 1'b0, 1'b0);

    // 6: back-to-back, second start on the tx_done cycle.
    load_fifo(2, 1'b0);
    model_push(PID_ACK, 0);
    model_push(PID_DATA0, 2);
    pop_cnt = 0;
    pulse_start(PID_ACK);
    wait_done(30000);
    tx_start = 1'b1;
    tx_pid   = PID_DATA0;
    @(negedge sysclk);
    tx_start = 1'b0;
    chk(tx_busy === 1'b1 && {d_plus, d_minus} === 2'b01, "b2b_immediate_sync",
        int'({tx_busy, d_plus, d_minus}), 3'b101);
    wait_done(30000);
    chk(pop_cnt == 2, "b2b_pop_count", pop_cnt, 2);
    fifo_q.delete();

    k = 0;
    while (exp_len_q.size() != 0 && k < 2000) begin
      @(negedge sysclk);
      k++;
    end
    repeat (4) @(negedge sysclk);
    chk(exp_len_q.size() == 0 && exp_sym_q.size() == 0, "scoreboard_drained",
        exp_sym_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
